// File: rtl/l1i_inv_ctrl.sv
// L1I tag-array invalidation sequencer: walks every set after reset and on
// each accepted flush request, then holds cache_ready until the next walk.
module l1i_inv_ctrl #(
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_gnt,
  input  logic             flush_req,
  output logic             inv_we,
  output logic [IDX_W-1:0] inv_idx,
  output logic             cache_ready,
  output logic             flush_done
);

  typedef enum logic [1:0] {RST_WAIT, INIT, READY, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             walking, last;

  assign walking = (state == INIT) || (state == FLUSH);
  // Final set of a walk is written at this edge.
  assign last    = walking && inv_gnt && (idx == IDX_W'(SETS - 1));

  assign inv_we  = walking;
  assign inv_idx = idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      RST_WAIT: begin
        state_nxt = INIT;
        idx_nxt   = '0;
      end
      INIT, FLUSH: begin
        if (inv_gnt) begin
          idx_nxt = last ? '0 : idx + IDX_W'(1);
          if (last) state_nxt = READY;
        end
      end
      READY: begin
        // flush_req is still high during the done pulse; that is not a new request.
        if (flush_req && !flush_done) begin
          state_nxt = FLUSH;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RST_WAIT;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_WAIT;
      idx         <= '0;
      cache_ready <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cache_ready <= (state_nxt == READY);
      flush_done  <= (state == FLUSH) && last;
    end
  end

endmodule

// File: tb/tb_l1i_inv_ctrl.sv
// Directed bench for l1i_inv_ctrl: scoreboard of expected write indices plus
// latency, handshake and reset checks; a second SETS=2 instance covers the corner.
module tb_l1i_inv_ctrl;

  logic       clk = 1'b0;
  logic       rst, inv_gnt, flush_req;
  logic       inv_we, cache_ready, flush_done;
  logic [5:0] inv_idx;

  logic       rst_s, gnt_s, req_s;
  logic       we_s, rdy_s, fd_s;
  logic [0:0] idx_s;

  int total  = 0;
  int passed = 0;
  int fd_count = 0;
  int exp_q[$];
  int n, stalls;

  always #5 clk = ~clk;

  l1i_inv_ctrl #(.SETS(64)) u_dut (
    .clk(clk), .rst(rst), .inv_gnt(inv_gnt), .flush_req(flush_req),
    .inv_we(inv_we), .inv_idx(inv_idx), .cache_ready(cache_ready), .flush_done(flush_done)
  );

  l1i_inv_ctrl #(.SETS(2)) u_small (
    .clk(clk), .rst(rst_s), .inv_gnt(gnt_s), .flush_req(req_s),
    .inv_we(we_s), .inv_idx(idx_s), .cache_ready(rdy_s), .flush_done(fd_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_walk(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(i % 64);
  endtask

  // A write completes at the next posedge when inv_we && inv_gnt; inputs settle #1 after posedge.
  always @(negedge clk) begin
    if (flush_done) fd_count++;
    if (inv_we && inv_gnt) begin
      chk("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("write_idx", inv_idx, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; rst_s = 1'b1; inv_gnt = 1'b1; flush_req = 1'b0;
    gnt_s = 1'b1; req_s = 1'b0;
    repeat (3) tick();
    chk("rst_we",    inv_we, 0);
    chk("rst_idx",   inv_idx, 0);
    chk("rst_ready", cache_ready, 0);
    chk("rst_done",  flush_done, 0);

    // Init walk, grant always high
    push_walk(64);
    rst = 1'b0;
    tick(); n = 1;
    chk("init_we_rise", inv_we, 1);
    chk("init_first_idx", inv_idx, 0);
    while (!cache_ready && n < 300) begin tick(); n++; end
    chk("init_latency", n, 65);
    chk("init_q_empty", exp_q.size(), 0);
    chk("init_no_done", fd_count, 0);

    // Init walk with grant low every third cycle
    rst = 1'b1; tick();
    push_walk(64);
    rst = 1'b0; n = 0; stalls = 0;
    do begin
      inv_gnt = (n % 3) != 2;
      if (!inv_gnt && inv_we) stalls++;
      tick(); n++;
    end while (!cache_ready && n < 400);
    inv_gnt = 1'b1;
    chk("stalls_seen", stalls > 0, 1);
    chk("stall_latency", n, 65 + stalls);
    chk("stall_q_empty", exp_q.size(), 0);
    chk("stall_no_done", fd_count, 0);

    // Flush from READY
    push_walk(64);
    flush_req = 1'b1;
    tick();
    chk("flush_ready_fall", cache_ready, 0);
    chk("flush_we", inv_we, 1);
    chk("flush_first_idx", inv_idx, 0);
    n = 0;
    while (!flush_done && n < 300) begin tick(); n++; end
    chk("flush_latency", n, 64);
    chk("flush_ready_with_done", cache_ready, 1);
    flush_req = 1'b0;
    tick();
    chk("flush_done_pulse", flush_done, 0);
    repeat (4) tick();
    chk("flush_done_count", fd_count, 1);
    chk("flush_idle_we", inv_we, 0);
    chk("flush_idle_ready", cache_ready, 1);
    chk("flush_q_empty", exp_q.size(), 0);

    // Flush request raised during INIT
    rst = 1'b1; tick();
    rst = 1'b0;
    push_walk(128);
    n = 0;
    do begin
      if (n == 10) flush_req = 1'b1;
      tick(); n++;
    end while (!cache_ready && n < 300);
    chk("early_init_latency", n, 65);
    chk("early_no_done", fd_count, 1);
    tick();
    chk("early_ready_one_cycle", cache_ready, 0);
    chk("early_flush_we", inv_we, 1);
    n = 0;
    while (!flush_done && n < 300) begin tick(); n++; end
    chk("early_flush_latency", n, 64);
    flush_req = 1'b0;
    tick();
    chk("early_done_count", fd_count, 2);
    chk("early_q_empty", exp_q.size(), 0);

    // Reset in the middle of a flush walk
    push_walk(30);
    flush_req = 1'b1;
    tick();
    repeat (30) tick();
    chk("mid_idx30", inv_idx, 30);
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    inv_we, 0);
    chk("mid_rst_idx",   inv_idx, 0);
    chk("mid_rst_ready", cache_ready, 0);
    chk("mid_rst_done",  flush_done, 0);
    flush_req = 1'b0;
    tick();
    rst = 1'b0;
    push_walk(64);
    tick(); n = 1;
    chk("restart_we", inv_we, 1);
    chk("restart_idx", inv_idx, 0);
    while (!cache_ready && n < 300) begin tick(); n++; end
    chk("restart_latency", n, 65);
    chk("restart_no_done", fd_count, 2);
    chk("restart_q_empty", exp_q.size(), 0);

    // SETS=2 corner
    rst_s = 1'b0;
    tick();
    chk("s2_we0", we_s, 1);
    chk("s2_idx0", idx_s, 0);
    tick();
    chk("s2_we1", we_s, 1);
    chk("s2_idx1", idx_s, 1);
    tick();
    chk("s2_ready", rdy_s, 1);
    chk("s2_we_off", we_s, 0);
    chk("s2_wrap", idx_s, 0);
    chk("s2_no_done", fd_s, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
